// File: rtl/seven_seg_scan_driver_if.sv
// ============================================================================
// seven_seg_scan_driver_if : application-side and pin-side signals of the scan driver
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DUTY_BITS  = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_en;
  logic [DUTY_BITS-1:0]    brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output load, digits, dp_in, blank_in, lz_en, brightness,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  load, digits, dp_in, blank_in, lz_en, brightness,
    output seg, dp, an, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
// ============================================================================
// seven_seg_scan_driver : N-digit multiplexed common-anode 7-seg driver
// Revision: 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DUTY_BITS   = 4
) (
  input wire logic                  clk,
  input wire logic                  rst_n,
  seven_seg_scan_driver_if.slave    bus
);

  localparam int c_sub    = REFRESH_DIV >> DUTY_BITS;
  localparam int c_sub_w  = (c_sub > 1) ? $clog2(c_sub) : 1;
  localparam int c_slot_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b1111111;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [c_sub_w-1:0]      r_sub_cnt;
  logic [DUTY_BITS-1:0]    r_phase;
  logic [c_slot_w-1:0]     r_slot;

  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_lz;
  logic                    r_pend_v;

  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic                    r_act_lz;
  logic                    r_act_v;

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic                    w_sub_last;
  logic                    w_slot_tick;
  logic                    w_frame_tick;
  logic                    w_run;
  logic [NUM_DIGITS-1:0]   w_sup;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  logic [3:0]              w_nib;
  logic                    w_dark;

  assign w_sub_last   = (r_sub_cnt == c_sub_w'(c_sub - 1));
  assign w_slot_tick  = w_sub_last & (&r_phase);
  assign w_frame_tick = w_slot_tick & (r_slot == c_slot_w'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_cnt <= '0;
      r_phase   <= '0;
      r_slot    <= '0;
    end else if (w_sub_last) begin
      r_sub_cnt <= '0;
      r_phase   <= r_phase + DUTY_BITS'(1);
      if (w_slot_tick)
        r_slot <= (r_slot == c_slot_w'(NUM_DIGITS - 1)) ? '0 : r_slot + c_slot_w'(1);
    end else begin
      r_sub_cnt <= r_sub_cnt + c_sub_w'(1);
    end
  end

  // Pending and active may both update on one edge: active takes the old pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '1;
      r_pend_lz     <= 1'b0;
      r_pend_v      <= 1'b0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
      r_act_blank   <= '1;
      r_act_lz      <= 1'b0;
      r_act_v       <= 1'b0;
    end else begin
      if (w_frame_tick && r_pend_v) begin
        r_act_digits <= r_pend_digits;
        r_act_dp     <= r_pend_dp;
        r_act_blank  <= r_pend_blank;
        r_act_lz     <= r_pend_lz;
        r_act_v      <= 1'b1;
      end
      if (bus.load) begin
        r_pend_digits <= bus.digits;
        r_pend_dp     <= bus.dp_in;
        r_pend_blank  <= bus.blank_in;
        r_pend_lz     <= bus.lz_en;
        r_pend_v      <= 1'b1;
      end else if (w_frame_tick) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  // Suppression propagates down from the most significant digit.
  always_comb begin
    w_sup = '0;
    w_run = r_act_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run    = w_run & (r_act_digits[4*i +: 4] == 4'h0) & ~r_act_dp[i];
      w_sup[i] = w_run;
    end
  end

  always_comb begin
    w_an_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_an_sel[i] = (c_slot_w'(i) != r_slot);
  end

  assign w_nib  = r_act_digits[4*r_slot +: 4];
  assign w_dark = r_act_blank[r_slot] | w_sup[r_slot];

  // Anodes stay off until a first load has reached the active buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= 7'b1111111;
      r_dp          <= 1'b1;
      r_an          <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_dark ? 7'b1111111 : hex_to_seg(w_nib);
      r_dp          <= w_dark | ~r_act_dp[r_slot];
      r_an          <= (r_act_v && (r_phase <= bus.brightness)) ? w_an_sel : '1;
      r_frame_start <= w_frame_tick;
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.an          = r_an;
  assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
// ============================================================================
// tb_seven_seg_scan_driver : directed self-checking bench for the scan driver
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_driver;
  localparam int N  = 4;
  localparam int RD = 32;
  localparam int DB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.NUM_DIGITS(N), .DUTY_BITS(DB)) bus ();

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DUTY_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] cap_seg [128];
  logic       cap_dp  [128];
  logic [3:0] cap_an  [128];
  logic       cap_fs  [128];
  bit         cap_ok;

  // Records one full frame (128 cycles); optionally first waits for frame_start.
  task automatic capture(input bit wait_fs);
    cap_ok = 1'b1;
    if (wait_fs) begin
      cap_ok = 1'b0;
      for (int i = 0; i < 300 && !cap_ok; i++) begin
        @(negedge clk);
        if (bus.frame_start === 1'b1) cap_ok = 1'b1;
      end
    end
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      cap_seg[k] = bus.seg;
      cap_dp[k]  = bus.dp;
      cap_an[k]  = bus.an;
      cap_fs[k]  = bus.frame_start;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                         input logic [3:0] blk, input logic lz);
    bus.digits   = d;
    bus.dp_in    = dpv;
    bus.blank_in = blk;
    bus.lz_en    = lz;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.seg !== 7'b1111111) begin bad++; $display("FAIL rst_seg got=%b exp=1111111", bus.seg); end
    total++; if (bus.dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b exp=1", bus.dp); end
    total++; if (bus.an !== 4'b1111) begin bad++; $display("FAIL rst_an got=%b exp=1111", bus.an); end
    total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", bus.frame_start); end
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.frame_start === 1'b1) break;
    end
    total++; if (cnt !== 128) begin bad++; $display("FAIL rst_first_fs got=%0d exp=128", cnt); end
  endtask

  task automatic test_idle();
    capture(1'b1);
    total++; if (!cap_ok) begin bad++; $display("FAIL idle_wait got=timeout exp=frame_start"); end
    for (int k = 0; k < 128; k++) begin
      total++; if (cap_an[k] !== 4'b1111) begin bad++; $display("FAIL idle_an k=%0d got=%b exp=1111", k, cap_an[k]); end
      total++; if (cap_seg[k] !== 7'b1111111) begin bad++; $display("FAIL idle_seg k=%0d got=%b exp=1111111", k, cap_seg[k]); end
      total++; if (cap_fs[k] !== (k == 127)) begin bad++; $display("FAIL idle_fs k=%0d got=%b exp=%b", k, cap_fs[k], k == 127); end
    end
  endtask

  task automatic test_display();
    logic [6:0] es [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    logic [3:0] ea;
    do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    capture(1'b1);
    total++; if (!cap_ok) begin bad++; $display("FAIL disp_wait got=timeout exp=frame_start"); end
    for (int k = 0; k < 128; k++) begin
      ea = 4'b1111 ^ (4'b0001 << (k / 32));
      total++; if (cap_seg[k] !== es[k/32]) begin bad++; $display("FAIL disp_seg k=%0d got=%b exp=%b", k, cap_seg[k], es[k/32]); end
      total++; if (cap_an[k] !== ea) begin bad++; $display("FAIL disp_an k=%0d got=%b exp=%b", k, cap_an[k], ea); end
      total++; if (cap_dp[k] !== 1'b1) begin bad++; $display("FAIL disp_dp k=%0d got=%b exp=1", k, cap_dp[k]); end
      total++; if (cap_fs[k] !== (k == 127)) begin bad++; $display("FAIL disp_fs k=%0d got=%b exp=%b", k, cap_fs[k], k == 127); end
    end
  endtask

  task automatic test_brightness();
    logic [6:0] es [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    logic [3:0] ea;
    bus.brightness = 2'd0;
    capture(1'b0);
    for (int k = 0; k < 128; k++) begin
      ea = (((k % 32) / 8) == 0) ? (4'b1111 ^ (4'b0001 << (k / 32))) : 4'b1111;
      total++; if (cap_an[k] !== ea) begin bad++; $display("FAIL bri_an k=%0d got=%b exp=%b", k, cap_an[k], ea); end
      total++; if (cap_seg[k] !== es[k/32]) begin bad++; $display("FAIL bri_seg k=%0d got=%b exp=%b", k, cap_seg[k], es[k/32]); end
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_blank_dp();
    logic [6:0] es  [4] = '{7'b0111000, 7'b1111111, 7'b0010010, 7'b1001111};
    logic       edp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] ea;
    do_load(16'h12AF, 4'b0011, 4'b0010, 1'b0);
    capture(1'b1);
    total++; if (!cap_ok) begin bad++; $display("FAIL blank_wait got=timeout exp=frame_start"); end
    for (int k = 0; k < 128; k++) begin
      ea = 4'b1111 ^ (4'b0001 << (k / 32));
      total++; if (cap_seg[k] !== es[k/32]) begin bad++; $display("FAIL blank_seg k=%0d got=%b exp=%b", k, cap_seg[k], es[k/32]); end
      total++; if (cap_dp[k] !== edp[k/32]) begin bad++; $display("FAIL blank_dp k=%0d got=%b exp=%b", k, cap_dp[k], edp[k/32]); end
      total++; if (cap_an[k] !== ea) begin bad++; $display("FAIL blank_an k=%0d got=%b exp=%b", k, cap_an[k], ea); end
    end
  endtask

  task automatic test_lz();
    logic [6:0] es1 [4] = '{7'b0000001, 7'b1001100, 7'b1111111, 7'b1111111};
    logic [6:0] es2 [4] = '{7'b0000001, 7'b1001100, 7'b0000001, 7'b0000001};
    logic       ed2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ea;
    do_load(16'h0040, 4'b0000, 4'b0000, 1'b1);
    capture(1'b1);
    total++; if (!cap_ok) begin bad++; $display("FAIL lz1_wait got=timeout exp=frame_start"); end
    for (int k = 0; k < 128; k++) begin
      ea = 4'b1111 ^ (4'b0001 << (k / 32));
      total++; if (cap_seg[k] !== es1[k/32]) begin bad++; $display("FAIL lz1_seg k=%0d got=%b exp=%b", k, cap_seg[k], es1[k/32]); end
      total++; if (cap_dp[k] !== 1'b1) begin bad++; $display("FAIL lz1_dp k=%0d got=%b exp=1", k, cap_dp[k]); end
      total++; if (cap_an[k] !== ea) begin bad++; $display("FAIL lz1_an k=%0d got=%b exp=%b", k, cap_an[k], ea); end
    end
    do_load(16'h0040, 4'b1000, 4'b0000, 1'b1);
    capture(1'b1);
    total++; if (!cap_ok) begin bad++; $display("FAIL lz2_wait got=timeout exp=frame_start"); end
    for (int k = 0; k < 128; k++) begin
      total++; if (cap_seg[k] !== es2[k/32]) begin bad++; $display("FAIL lz2_seg k=%0d got=%b exp=%b", k, cap_seg[k], es2[k/32]); end
      total++; if (cap_dp[k] !== ed2[k/32]) begin bad++; $display("FAIL lz2_dp k=%0d got=%b exp=%b", k, cap_dp[k], ed2[k/32]); end
    end
  endtask

  // Entered right after a frame_start sample; the boundary cycle is 127 cycles on.
  task automatic test_back_to_back();
    repeat (20) @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    repeat (106) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    total++; if (bus.frame_start !== 1'b1) begin bad++; $display("FAIL b2b_align got=%b exp=1", bus.frame_start); end
    capture(1'b0);
    for (int k = 0; k < 128; k++) begin
      total++; if (cap_seg[k] !== 7'b1001111) begin bad++; $display("FAIL b2b_f1_seg k=%0d got=%b exp=1001111", k, cap_seg[k]); end
    end
    total++; if (cap_fs[127] !== 1'b1) begin bad++; $display("FAIL b2b_f1_fs got=%b exp=1", cap_fs[127]); end
    capture(1'b0);
    for (int k = 0; k < 128; k++) begin
      total++; if (cap_seg[k] !== 7'b0010010) begin bad++; $display("FAIL b2b_f2_seg k=%0d got=%b exp=0010010", k, cap_seg[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    repeat (74) @(negedge clk);
    total++; if (bus.an !== 4'b1011) begin bad++; $display("FAIL mid_pre_an got=%b exp=1011", bus.an); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.an !== 4'b1111) begin bad++; $display("FAIL mid_an got=%b exp=1111", bus.an); end
    total++; if (bus.seg !== 7'b1111111) begin bad++; $display("FAIL mid_seg got=%b exp=1111111", bus.seg); end
    total++; if (bus.dp !== 1'b1) begin bad++; $display("FAIL mid_dp got=%b exp=1", bus.dp); end
    total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL mid_fs got=%b exp=0", bus.frame_start); end
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.frame_start === 1'b1) break;
    end
    total++; if (cnt !== 128) begin bad++; $display("FAIL mid_first_fs got=%0d exp=128", cnt); end
    capture(1'b0);
    for (int k = 0; k < 128; k++) begin
      total++; if (cap_an[k] !== 4'b1111) begin bad++; $display("FAIL mid_dark_an k=%0d got=%b exp=1111", k, cap_an[k]); end
      total++; if (cap_seg[k] !== 7'b1111111) begin bad++; $display("FAIL mid_dark_seg k=%0d got=%b exp=1111111", k, cap_seg[k]); end
    end
  endtask

  initial begin
    bus.load       = 1'b0;
    bus.digits     = '0;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.lz_en      = 1'b0;
    bus.brightness = 2'd3;
    test_reset();
    test_idle();
    test_display();
    test_brightness();
    test_blank_dp();
    test_lz();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
